// File: rtl/vregfile_control_arbiter_pkg.sv
// Shared definitions for the vector control register file arbiter.
//   - well-known control register indices (vl and the matmul mask registers)
//   - write-side state encoding
//   - round-robin pointer advance helper
package vregfile_control_arbiter_pkg;

  localparam int unsigned VL_REG     = 0;
  localparam int unsigned MASK_BCOLS = 29;
  localparam int unsigned MASK_ACOLS = 30;
  localparam int unsigned MASK_AROWS = 31;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } wr_state_e;

  // Pointer value that follows a winner: one past it, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    if (idx + 1 >= n) return 0;
    return idx + 1;
  endfunction

endpackage

// File: rtl/vregfile_control_rr_pick.sv
// Round-robin picker: scans the valid vector starting at ptr (wrapping modulo N)
// and returns the first set position.
//   valid  in   N    candidate requests
//   ptr    in   PW   scan start position (always < N)
//   grant  out  N    one-hot winner, zero when nothing is valid
//   idx    out  PW   winner index (0 when nothing is valid)
//   any    out  1    a winner exists
module vregfile_control_rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  // One spare bit so ptr + k never overflows before the wrap subtraction.
  logic [PW:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) pos = pos - (PW+1)'(N);
      if (!any && valid[pos[PW-1:0]]) begin
        any                 = 1'b1;
        grant[pos[PW-1:0]]  = 1'b1;
        idx                 = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/vregfile_control_arbiter.sv
// Arbiter sharing the vector control register file (read port a, write port c)
// between NUM_REQ requesters. Reads and writes have independent round-robin
// pointers. A write with wr_lock set keeps write ownership so multi-register
// sequences (mask regs 29..31 + vl) land atomically. A read that targets the
// register being written in the same cycle is held off one cycle, because the
// RAM's read-during-write result is undefined.
//
// Optional build macro: VREGFILE_CTRL_ARB_BYPASS_EN
//   When defined, a same-register read+write is granted together and the read
//   response returns a registered copy of the write data instead of RAM data.
//
// Ports
//   clk, reset             clock / async active-high reset
//   rd_valid, rd_reg       per-requester read requests and register indices
//   rd_ready               one-hot read grant
//   rsp_valid, rsp_data    one-hot read response one cycle after grant
//   wr_valid, wr_reg,
//   wr_data, wr_lock       per-requester write requests
//   wr_ready               one-hot write grant
//   a_en, a_reg            register file read port
//   a_readdataout          register file read data (1-cycle latency)
//   c_we, c_reg,
//   c_writedatain          register file write port
//   locked                 write lock currently held
//
// Write FSM
//   state  | meaning
//   IDLE   | any write requester may win round-robin
//   LOCKED | only owner_q may write; others stall until owner writes with wr_lock=0
module vregfile_control_arbiter
  import vregfile_control_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int REGIDWIDTH = 5,
  parameter int WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            rd_valid,
  input  logic [NUM_REQ*REGIDWIDTH-1:0] rd_reg,
  output logic [NUM_REQ-1:0]            rd_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [WIDTH-1:0]              rsp_data,
  input  logic [NUM_REQ-1:0]            wr_valid,
  input  logic [NUM_REQ*REGIDWIDTH-1:0] wr_reg,
  input  logic [NUM_REQ*WIDTH-1:0]      wr_data,
  input  logic [NUM_REQ-1:0]            wr_lock,
  output logic [NUM_REQ-1:0]            wr_ready,
  output logic                          a_en,
  output logic [REGIDWIDTH-1:0]         a_reg,
  input  logic [WIDTH-1:0]              a_readdataout,
  output logic                          c_we,
  output logic [REGIDWIDTH-1:0]         c_reg,
  output logic [WIDTH-1:0]              c_writedatain,
  output logic                          locked
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  wr_state_e            state_q, state_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        rd_ptr_q, wr_ptr_q;
  logic [NUM_REQ-1:0]   rsp_sel_q;

  logic [NUM_REQ-1:0]   owner_mask;
  logic [NUM_REQ-1:0]   wr_elig, wr_grant;
  logic [PW-1:0]        wr_idx;
  logic                 wr_any;

  logic [NUM_REQ-1:0]   rd_elig, rd_grant;
  logic [PW-1:0]        rd_idx;
  logic                 rd_any;

  // ---------------- write side ----------------
  assign owner_mask = NUM_REQ'(1) << owner_q;
  assign wr_elig    = (state_q == LOCKED) ? (wr_valid & owner_mask) : wr_valid;

  vregfile_control_rr_pick #(.N(NUM_REQ), .PW(PW)) u_wr_pick (
    .valid (wr_elig),
    .ptr   (wr_ptr_q),
    .grant (wr_grant),
    .idx   (wr_idx),
    .any   (wr_any)
  );

  assign wr_ready      = wr_grant;
  assign c_we          = wr_any;
  assign c_reg         = wr_reg[wr_idx*REGIDWIDTH +: REGIDWIDTH];
  assign c_writedatain = wr_data[wr_idx*WIDTH +: WIDTH];
  assign locked        = (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (wr_any && wr_lock[wr_idx]) begin
          state_d = LOCKED;
          owner_d = wr_idx;
        end
      end
      LOCKED: begin
        // wr_any here can only be the owner, since others are masked out.
        if (wr_any && !wr_lock[wr_idx]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- read side ----------------
`ifdef VREGFILE_CTRL_ARB_BYPASS_EN
  assign rd_elig = rd_valid;
`else
  logic [NUM_REQ-1:0] rd_hazard;

  always_comb begin
    rd_hazard = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_hazard[i] = c_we && (rd_reg[i*REGIDWIDTH +: REGIDWIDTH] == c_reg);
    end
  end

  assign rd_elig = rd_valid & ~rd_hazard;
`endif

  vregfile_control_rr_pick #(.N(NUM_REQ), .PW(PW)) u_rd_pick (
    .valid (rd_elig),
    .ptr   (rd_ptr_q),
    .grant (rd_grant),
    .idx   (rd_idx),
    .any   (rd_any)
  );

  assign rd_ready  = rd_grant;
  assign a_en      = rd_any;
  assign a_reg     = rd_reg[rd_idx*REGIDWIDTH +: REGIDWIDTH];
  assign rsp_valid = rsp_sel_q;

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rsp_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rsp_sel_q <= rd_grant;
      if (rd_any) rd_ptr_q <= PW'(rr_next(32'(rd_idx), NUM_REQ));
      if (wr_any) wr_ptr_q <= PW'(rr_next(32'(wr_idx), NUM_REQ));
    end
  end

  // ---------------- response data ----------------
`ifdef VREGFILE_CTRL_ARB_BYPASS_EN
  logic             byp_q;
  logic [WIDTH-1:0] byp_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_q <= rd_any && c_we && (a_reg == c_reg);
      if (rd_any && c_we && (a_reg == c_reg)) byp_data_q <= c_writedatain;
    end
  end

  assign rsp_data = !(|rsp_sel_q) ? '0 :
                    byp_q         ? byp_data_q : a_readdataout;
`else
  assign rsp_data = (|rsp_sel_q) ? a_readdataout : '0;
`endif

endmodule

// File: tb/tb_vregfile_control_arbiter.sv
module tb_vregfile_control_arbiter;

  localparam int N  = 3;
  localparam int RW = 5;
  localparam int W  = 32;
`ifdef VREGFILE_CTRL_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      rd_valid;
  logic [N*RW-1:0]   rd_reg;
  logic [N-1:0]      rd_ready;
  logic [N-1:0]      rsp_valid;
  logic [W-1:0]      rsp_data;
  logic [N-1:0]      wr_valid;
  logic [N*RW-1:0]   wr_reg;
  logic [N*W-1:0]    wr_data;
  logic [N-1:0]      wr_lock;
  logic [N-1:0]      wr_ready;
  logic              a_en;
  logic [RW-1:0]     a_reg;
  logic [W-1:0]      a_readdataout;
  logic              c_we;
  logic [RW-1:0]     c_reg;
  logic [W-1:0]      c_writedatain;
  logic              locked;

  vregfile_control_arbiter #(.NUM_REQ(N), .REGIDWIDTH(RW), .WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .rd_valid      (rd_valid),
    .rd_reg        (rd_reg),
    .rd_ready      (rd_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .wr_valid      (wr_valid),
    .wr_reg        (wr_reg),
    .wr_data       (wr_data),
    .wr_lock       (wr_lock),
    .wr_ready      (wr_ready),
    .a_en          (a_en),
    .a_reg         (a_reg),
    .a_readdataout (a_readdataout),
    .c_we          (c_we),
    .c_reg         (c_reg),
    .c_writedatain (c_writedatain),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  // Register file behind the arbiter: synchronous read, 1-cycle latency.
  logic [W-1:0] mem [32] = '{default: '0};
  always @(posedge clk) begin
    if (c_we) mem[c_reg] <= c_writedatain;
    if (a_en) a_readdataout <= mem[a_reg];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: architectural view of arbitration state and register contents.
  typedef struct { int req; logic [W-1:0] data; int due; } rsp_t;
  rsp_t         sbq[$];
  logic [W-1:0] shadow [32] = '{default: '0};
  int m_rd_ptr = 0, m_wr_ptr = 0, m_owner = -1;
  int last_rd_win = -1, last_wr_win = -1;

  task automatic model_reset();
    m_rd_ptr = 0; m_wr_ptr = 0; m_owner = -1;
    sbq.delete();
  endtask

  // Check one cycle's combinational grants against the model, then advance it.
  task automatic step();
    int wwin, rwin, rreg;
    logic [RW-1:0] wreg;
    logic [W-1:0]  wdat;
    rsp_t e;
    @(negedge clk);
    wwin = -1; rwin = -1; wreg = '0; wdat = '0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_wr_ptr + k) % N;
      if (wwin < 0 && wr_valid[i] && (m_owner < 0 || m_owner == i)) wwin = i;
    end
    if (wwin >= 0) begin
      wreg = wr_reg[wwin*RW +: RW];
      wdat = wr_data[wwin*W +: W];
    end
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rd_ptr + k) % N;
      if (rwin < 0 && rd_valid[i] &&
          (BYP || wwin < 0 || rd_reg[i*RW +: RW] != wreg)) rwin = i;
    end
    chk("wr_ready", 64'(wr_ready), (wwin >= 0) ? 64'(1) << wwin : 64'(0));
    chk("rd_ready", 64'(rd_ready), (rwin >= 0) ? 64'(1) << rwin : 64'(0));
    chk("c_we",     64'(c_we),     64'(wwin >= 0));
    chk("a_en",     64'(a_en),     64'(rwin >= 0));
    chk("locked",   64'(locked),   64'(m_owner >= 0));
    if (wwin >= 0) begin
      chk("c_reg",         64'(c_reg),         64'(wreg));
      chk("c_writedatain", 64'(c_writedatain), 64'(wdat));
    end
    if (rwin >= 0) begin
      rreg = int'(rd_reg[rwin*RW +: RW]);
      chk("a_reg", 64'(a_reg), 64'(rreg));
      e.req  = rwin;
      e.data = (BYP && wwin >= 0 && rreg == int'(wreg)) ? wdat : shadow[rreg];
      e.due  = cyc + 1;
      sbq.push_back(e);
      m_rd_ptr = (rwin + 1) % N;
    end
    if (wwin >= 0) begin
      shadow[wreg] = wdat;
      m_wr_ptr = (wwin + 1) % N;
      if (m_owner < 0 && wr_lock[wwin]) m_owner = wwin;
      else if (m_owner >= 0 && !wr_lock[wwin]) m_owner = -1;
    end
    last_rd_win = rwin;
    last_wr_win = wwin;
    @(posedge clk);
    #1;
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (rsp_valid != '0) begin
          chk("rsp_onehot", 64'($onehot(rsp_valid)), 64'(1));
          if (sbq.size() == 0) begin
            chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
          end else begin
            e = sbq.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.req);
            chk("rsp_data",  64'(rsp_data),  64'(e.data));
          end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
          e = sbq.pop_front();
          chk("rsp_missing", 64'(rsp_valid), 64'(1) << e.req);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    rd_valid = '0; rd_reg = '0; wr_valid = '0; wr_reg = '0; wr_data = '0; wr_lock = '0;
  endtask

  function automatic logic [RW-1:0] pick_reg();
    case ($urandom_range(0, 5))
      0:       return RW'(0);
      1:       return RW'(5);
      2:       return RW'(6);
      3:       return RW'(29);
      4:       return RW'(30);
      default: return RW'(31);
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_data",  64'(rsp_data),  64'(0));
    chk("reset_locked",    64'(locked),    64'(0));
    chk("reset_rd_ready",  64'(rd_ready),  64'(0));
    chk("reset_wr_ready",  64'(wr_ready),  64'(0));
    chk("reset_a_en",      64'(a_en),      64'(0));
    chk("reset_c_we",      64'(c_we),      64'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // req0 reads vl straight after reset
    rd_valid = 3'b001; rd_reg[0*RW +: RW] = RW'(0);
    step();
    idle_inputs();
    step();

    // req0 writes vl=0x40 while req2 reads vl in the same cycle
    wr_valid = 3'b001; wr_reg[0*RW +: RW] = RW'(0); wr_data[0*W +: W] = 32'h40;
    rd_valid = 3'b100; rd_reg[2*RW +: RW] = RW'(0);
    step();
    wr_valid = '0;
    if (last_rd_win != 2) step();
    idle_inputs();
    step();

    // req1 locked mask sequence 31,30,29 while req2 keeps requesting
    wr_valid = 3'b110;
    wr_reg[2*RW +: RW] = RW'(6); wr_data[2*W +: W] = 32'h66;
    wr_reg[1*RW +: RW] = RW'(31); wr_data[1*W +: W] = 32'h0F; wr_lock = 3'b010;
    step();
    wr_reg[1*RW +: RW] = RW'(30); wr_data[1*W +: W] = 32'h1E; wr_lock = 3'b010;
    step();
    wr_reg[1*RW +: RW] = RW'(29); wr_data[1*W +: W] = 32'h2D; wr_lock = 3'b000;
    step();
    wr_valid = 3'b100;
    step();
    idle_inputs();
    step();

    // read reg5 and write reg6 in the same cycle by different requesters
    wr_valid = 3'b001; wr_reg[0*RW +: RW] = RW'(5); wr_data[0*W +: W] = 32'h55;
    step();
    idle_inputs();
    rd_valid = 3'b001; rd_reg[0*RW +: RW] = RW'(5);
    wr_valid = 3'b010; wr_reg[1*RW +: RW] = RW'(6); wr_data[1*W +: W] = 32'h77;
    step();
    idle_inputs();
    step();

    // reset while locked with a response pending
    wr_valid = 3'b001; wr_reg[0*RW +: RW] = RW'(31); wr_data[0*W +: W] = 32'hAB; wr_lock = 3'b001;
    rd_valid = 3'b010; rd_reg[1*RW +: RW] = RW'(5);
    step();
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("midreset_locked",    64'(locked),    64'(0));
    chk("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("midreset_rsp_data",  64'(rsp_data),  64'(0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_valid = 3'b111; wr_valid = 3'b111;
    rd_reg  = {RW'(1), RW'(2), RW'(3)};
    wr_reg  = {RW'(7), RW'(8), RW'(9)};
    wr_data = {32'h3, 32'h2, 32'h1};
    step();
    idle_inputs();
    step();

    // all three read continuously
    rd_valid = 3'b111;
    rd_reg  = {RW'(30), RW'(6), RW'(5)};
    repeat (6) step();
    idle_inputs();
    step();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < N; i++) begin
        rd_reg[i*RW +: RW] = pick_reg();
        wr_reg[i*RW +: RW] = pick_reg();
        wr_data[i*W +: W]  = $urandom;
      end
      rd_valid = N'($urandom);
      wr_valid = N'($urandom);
      wr_lock  = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        rd_valid = '0; wr_valid = '0;
      end
      step();
    end

    // release any lock and drain outstanding responses
    idle_inputs();
    if (m_owner >= 0) begin
      wr_valid = N'(1) << m_owner;
      wr_reg[m_owner*RW +: RW] = RW'(0);
      wr_data[m_owner*W +: W]  = 32'h1;
      step();
      idle_inputs();
    end
    repeat (3) step();
    chk("sb_drained", 64'(sbq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
